// File: rtl/ps2_keyboard_rx_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: FSM encoding, scan-code
// constants and small frame-check helpers.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_LSHIFT = 8'h12;
  localparam logic [7:0] PS2_RSHIFT = 8'h59;

  // Odd parity: the data bits plus the parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
    return ^{data, parity};
  endfunction

  function automatic logic is_shift_code(input logic [7:0] code);
    return (code == PS2_LSHIFT) || (code == PS2_RSHIFT);
  endfunction

endpackage

// File: rtl/ps2_keyboard_rx_if.sv
// Character delivery bus from the PS/2 receiver to the keyboard register block.
interface ps2_keyboard_rx_if;
  logic [7:0] ascii;
  logic       ld_ascii;
  logic       frame_err;

  modport master (output ascii, output ld_ascii, output frame_err);
  modport slave  (input  ascii, input  ld_ascii, input  frame_err);
endinterface

// File: rtl/ps2_keyboard_rx_scancode_to_ascii.sv
// Combinational Set-2 scan code to ASCII lookup; unmapped codes give 8'h00.
module ps2_scancode_to_ascii (
  input  logic       shift,
  input  logic [7:0] code,
  output logic [7:0] ascii
);

  logic [7:0] lower_s;
  logic [7:0] shifted_s;
  logic       is_letter_s;

  // Unshifted character for every mapped key.
  always_comb begin
    lower_s = 8'h00;
    case (code)
      8'h1C: lower_s = 8'h61;  8'h32: lower_s = 8'h62;  8'h21: lower_s = 8'h63;
      8'h23: lower_s = 8'h64;  8'h24: lower_s = 8'h65;  8'h2B: lower_s = 8'h66;
      8'h34: lower_s = 8'h67;  8'h33: lower_s = 8'h68;  8'h43: lower_s = 8'h69;
      8'h3B: lower_s = 8'h6A;  8'h42: lower_s = 8'h6B;  8'h4B: lower_s = 8'h6C;
      8'h3A: lower_s = 8'h6D;  8'h31: lower_s = 8'h6E;  8'h44: lower_s = 8'h6F;
      8'h4D: lower_s = 8'h70;  8'h15: lower_s = 8'h71;  8'h2D: lower_s = 8'h72;
      8'h1B: lower_s = 8'h73;  8'h2C: lower_s = 8'h74;  8'h3C: lower_s = 8'h75;
      8'h2A: lower_s = 8'h76;  8'h1D: lower_s = 8'h77;  8'h22: lower_s = 8'h78;
      8'h35: lower_s = 8'h79;  8'h1A: lower_s = 8'h7A;
      8'h16: lower_s = 8'h31;  8'h1E: lower_s = 8'h32;  8'h26: lower_s = 8'h33;
      8'h25: lower_s = 8'h34;  8'h2E: lower_s = 8'h35;  8'h36: lower_s = 8'h36;
      8'h3D: lower_s = 8'h37;  8'h3E: lower_s = 8'h38;  8'h46: lower_s = 8'h39;
      8'h45: lower_s = 8'h30;
      8'h29: lower_s = 8'h20;  8'h5A: lower_s = 8'h0D;  8'h66: lower_s = 8'h08;
      8'h0D: lower_s = 8'h09;
      default: lower_s = 8'h00;
    endcase
  end

  // Shifted digit row gives US symbols; other non-letters are shift-invariant.
  always_comb begin
    shifted_s = lower_s;
    case (code)
      8'h16: shifted_s = 8'h21;  8'h1E: shifted_s = 8'h40;  8'h26: shifted_s = 8'h23;
      8'h25: shifted_s = 8'h24;  8'h2E: shifted_s = 8'h25;  8'h36: shifted_s = 8'h5E;
      8'h3D: shifted_s = 8'h26;  8'h3E: shifted_s = 8'h2A;  8'h46: shifted_s = 8'h28;
      8'h45: shifted_s = 8'h29;
      default: shifted_s = lower_s;
    endcase
  end

  // Final selection; letters move to uppercase by clearing bit 5.
  always_comb begin
    is_letter_s = (lower_s >= 8'h61) && (lower_s <= 8'h7A);
    if (!shift) begin
      ascii = lower_s;
    end else if (is_letter_s) begin
      ascii = lower_s - 8'h20;
    end else begin
      ascii = shifted_s;
    end
  end

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 Set-2 keyboard receiver: conditions the pad signals, deframes 11-bit
// frames, tracks make/break/shift state and delivers ASCII with a load strobe.
module ps2_keyboard_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ps2_clk,
  input  logic              ps2_data,
  ps2_keyboard_rx_if.master kbd
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] clk_sync_r, data_sync_r;
  logic [FW-1:0]          filt_cnt_r;
  logic                   filt_r, filt_prev_r;
  logic                   clk_s, data_s, fall_s;

  ps2_state_e state_r, state_s;
  logic [2:0] bit_cnt_r, bit_cnt_s;
  logic [7:0] shreg_r, shreg_s;
  logic       parity_r, parity_s;
  logic [TW-1:0] tmo_cnt_r, tmo_cnt_s;
  logic       tmo_hit_s;
  logic       byte_valid_s, byte_valid_r;
  logic       err_s, frame_err_r;
  logic [7:0] byte_r;

  logic       shift_r, brk_r, ext_r;
  logic [7:0] ascii_r, lut_s;
  logic       ld_ascii_r;

  assign clk_s  = clk_sync_r[SYNC_STAGES-1];
  assign data_s = data_sync_r[SYNC_STAGES-1];
  assign fall_s = filt_prev_r & ~filt_r;

  // Pad synchronizers; idle bus level is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync_r  <= {SYNC_STAGES{1'b1}};
      data_sync_r <= {SYNC_STAGES{1'b1}};
    end else begin
      clk_sync_r  <= {clk_sync_r[SYNC_STAGES-2:0], ps2_clk};
      data_sync_r <= {data_sync_r[SYNC_STAGES-2:0], ps2_data};
    end
  end

  // Glitch filter: level follows only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_cnt_r  <= {FW{1'b0}};
      filt_r      <= 1'b1;
      filt_prev_r <= 1'b1;
    end else begin
      filt_prev_r <= filt_r;
      if (clk_s == filt_r) begin
        filt_cnt_r <= {FW{1'b0}};
      end else if (filt_cnt_r == FILT_LAST) begin
        filt_r     <= clk_s;
        filt_cnt_r <= {FW{1'b0}};
      end else begin
        filt_cnt_r <= filt_cnt_r + {{(FW-1){1'b0}}, 1'b1};
      end
    end
  end

  assign tmo_hit_s = (state_r != ST_IDLE) && (tmo_cnt_r == TMO_LAST) && !fall_s;

  // Frame FSM next state and datapath; a fall edge outranks the timeout.
  always_comb begin
    state_s      = state_r;
    bit_cnt_s    = bit_cnt_r;
    shreg_s      = shreg_r;
    parity_s     = parity_r;
    byte_valid_s = 1'b0;
    err_s        = 1'b0;
    if (tmo_hit_s) begin
      state_s = ST_IDLE;
      err_s   = 1'b1;
    end else if (fall_s) begin
      case (state_r)
        ST_IDLE: begin
          if (!data_s) begin
            state_s   = ST_DATA;
            bit_cnt_s = 3'd0;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_DATA: begin
          shreg_s = {data_s, shreg_r[7:1]};
          if (bit_cnt_r == 3'd7) begin
            state_s = ST_PARITY;
          end else begin
            bit_cnt_s = bit_cnt_r + 3'd1;
          end
        end
        ST_PARITY: begin
          parity_s = data_s;
          state_s  = ST_STOP;
        end
        ST_STOP: begin
          if (data_s && odd_parity_ok(shreg_r, parity_r)) begin
            byte_valid_s = 1'b1;
          end else begin
            err_s = 1'b1;
          end
          state_s = ST_IDLE;
        end
        default: state_s = ST_IDLE;
      endcase
    end else begin
      state_s = state_r;
    end

    if (fall_s || (state_r == ST_IDLE)) begin
      tmo_cnt_s = {TW{1'b0}};
    end else if (tmo_cnt_r != TMO_LAST) begin
      tmo_cnt_s = tmo_cnt_r + {{(TW-1){1'b0}}, 1'b1};
    end else begin
      tmo_cnt_s = tmo_cnt_r;
    end
  end

  // Frame FSM registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      bit_cnt_r    <= 3'd0;
      shreg_r      <= 8'h00;
      parity_r     <= 1'b0;
      tmo_cnt_r    <= {TW{1'b0}};
      byte_valid_r <= 1'b0;
      byte_r       <= 8'h00;
      frame_err_r  <= 1'b0;
    end else begin
      state_r      <= state_s;
      bit_cnt_r    <= bit_cnt_s;
      shreg_r      <= shreg_s;
      parity_r     <= parity_s;
      tmo_cnt_r    <= tmo_cnt_s;
      byte_valid_r <= byte_valid_s;
      frame_err_r  <= err_s;
      if (byte_valid_s) begin
        byte_r <= shreg_r;
      end else begin
        byte_r <= byte_r;
      end
    end
  end

  ps2_scancode_to_ascii u_lut (
    .shift (shift_r),
    .code  (byte_r),
    .ascii (lut_s)
  );

  // Make/break/extended tracking and character delivery.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_r    <= 1'b0;
      brk_r      <= 1'b0;
      ext_r      <= 1'b0;
      ascii_r    <= 8'h00;
      ld_ascii_r <= 1'b0;
    end else begin
      ld_ascii_r <= 1'b0;
      if (byte_valid_r) begin
        if (byte_r == PS2_EXT) begin
          ext_r <= 1'b1;
        end else if (byte_r == PS2_BRK) begin
          brk_r <= 1'b1;
        end else if (brk_r) begin
          if (is_shift_code(byte_r) && !ext_r) begin
            shift_r <= 1'b0;
          end
          brk_r <= 1'b0;
          ext_r <= 1'b0;
        end else if (is_shift_code(byte_r) && !ext_r) begin
          shift_r <= 1'b1;
        end else if (ext_r) begin
          ext_r <= 1'b0;
        end else if (lut_s != 8'h00) begin
          ascii_r    <= lut_s;
          ld_ascii_r <= 1'b1;
        end
      end
    end
  end

  assign kbd.ascii     = ascii_r;
  assign kbd.ld_ascii  = ld_ascii_r;
  assign kbd.frame_err = frame_err_r;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Self-checking bench for ps2_keyboard_rx: drives PS/2 frames on the pad pins
// and scores the delivered characters and frame errors against a queue.
module tb_ps2_keyboard_rx;

  localparam int H   = 8;
  localparam int TMO = 300;

  logic clk = 1'b0;
  logic reset;
  logic ps2_clk;
  logic ps2_data;

  ps2_keyboard_rx_if kbd ();

  ps2_keyboard_rx #(
    .SYNC_STAGES    (2),
    .FILTER_LEN     (4),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .kbd      (kbd)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int err_seen = 0;
  int err_exp = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;
  logic ld_prev = 1'b0;
  logic err_prev = 1'b0;

  // Scoreboard monitor, sampling on the falling clock edge.
  always @(negedge clk) begin
    if (reset) begin
      ld_prev  = 1'b0;
      err_prev = 1'b0;
    end else begin
      if (kbd.ld_ascii) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_ld got ascii=%h required no strobe", kbd.ascii);
        end else begin
          mon_exp = exp_q.pop_front();
          if (kbd.ascii !== mon_exp) begin
            failures++;
            $display("FAIL ascii got=%h required=%h", kbd.ascii, mon_exp);
          end
        end
      end
      if (kbd.frame_err) err_seen++;
      if (kbd.ld_ascii && kbd.frame_err) begin
        checks++; failures++;
        $display("FAIL ld_and_err_same_cycle got both=1 required exclusive");
      end
      if (ld_prev && kbd.ld_ascii) begin
        checks++; failures++;
        $display("FAIL ld_width got 2+ cycles required 1");
      end
      if (err_prev && kbd.frame_err) begin
        checks++; failures++;
        $display("FAIL err_width got 2+ cycles required 1");
      end
      ld_prev  = kbd.ld_ascii;
      err_prev = kbd.frame_err;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    wait_cycles(H);
    ps2_clk = 1'b0;
    wait_cycles(H);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] code, input logic flip_par, input logic flip_stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(code[i]);
    ps2_bit(~(^code) ^ flip_par);
    ps2_bit(~flip_stop);
    ps2_data = 1'b1;
    wait_cycles(2 * H);
  endtask

  task automatic check_drained(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      wait_cycles(1);
      n++;
    end
    wait_cycles(20);
    checks++;
    if (exp_q.size() !== 0) begin
      failures++;
      $display("FAIL %s_pending got=%0d required=0 outstanding chars", name, exp_q.size());
    end
    checks++;
    if (err_seen !== err_exp) begin
      failures++;
      $display("FAIL %s_frame_err got=%0d required=%0d", name, err_seen, err_exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    wait_cycles(5);
    reset = 1'b0;
    wait_cycles(2);
    checks++;
    if (kbd.ascii !== 8'h00) begin failures++; $display("FAIL reset_ascii got=%h required=00", kbd.ascii); end
    checks++;
    if (kbd.ld_ascii !== 1'b0) begin failures++; $display("FAIL reset_ld got=%b required=0", kbd.ld_ascii); end
    checks++;
    if (kbd.frame_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b required=0", kbd.frame_err); end
  endtask

  task automatic test_single();
    logic [7:0] code;
    int lat;
    code = 8'h1C;
    exp_q.push_back(8'h61);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(code[i]);
    ps2_bit(~(^code));
    ps2_data = 1'b1;
    wait_cycles(H);
    ps2_clk = 1'b0;
    lat = 0;
    while (kbd.ld_ascii !== 1'b1 && lat < 14) begin
      wait_cycles(1);
      lat++;
    end
    checks++;
    if (lat >= 14) begin
      failures++;
      $display("FAIL single_latency got no ld_ascii within %0d cycles required strobe", lat);
    end
    checks++;
    if (kbd.ascii !== 8'h61) begin failures++; $display("FAIL single_ascii got=%h required=61", kbd.ascii); end
    wait_cycles(H);
    ps2_clk = 1'b1;
    wait_cycles(2 * H);
    check_drained("single");
  endtask

  task automatic test_shift();
    send_frame(8'h12, 1'b0, 1'b0);
    exp_q.push_back(8'h41);
    send_frame(8'h1C, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h12, 1'b0, 1'b0);
    exp_q.push_back(8'h61);
    send_frame(8'h1C, 1'b0, 1'b0);
    check_drained("shift");
  endtask

  task automatic test_parity_error();
    send_frame(8'h16, 1'b1, 1'b0);
    err_exp++;
    send_frame(8'h2D, 1'b0, 1'b1);
    err_exp++;
    exp_q.push_back(8'h31);
    send_frame(8'h16, 1'b0, 1'b0);
    check_drained("parity");
  endtask

  task automatic test_timeout();
    logic [7:0] code;
    int n;
    int base;
    code = 8'h4D;
    base = err_seen;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(code[i]);
    ps2_data = 1'b1;
    n = 0;
    while (err_seen == base && n < TMO + 60) begin
      wait_cycles(1);
      n++;
    end
    err_exp++;
    checks++;
    if (err_seen !== base + 1) begin
      failures++;
      $display("FAIL timeout_err got=%0d required=%0d after %0d cycles", err_seen - base, 1, n);
    end
    wait_cycles(20);
    exp_q.push_back(8'h20);
    send_frame(8'h29, 1'b0, 1'b0);
    check_drained("timeout");
  endtask

  task automatic test_extended();
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0);
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0);
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'h12, 1'b0, 1'b0);
    exp_q.push_back(8'h0D);
    send_frame(8'h5A, 1'b0, 1'b0);
    exp_q.push_back(8'h6B);
    send_frame(8'h42, 1'b0, 1'b0);
    check_drained("extended");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(8'h61);
      send_frame(8'h1C, 1'b0, 1'b0);
    end
    send_frame(8'h59, 1'b0, 1'b0);
    exp_q.push_back(8'h21);
    send_frame(8'h16, 1'b0, 1'b0);
    exp_q.push_back(8'h29);
    send_frame(8'h45, 1'b0, 1'b0);
    exp_q.push_back(8'h09);
    send_frame(8'h0D, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h59, 1'b0, 1'b0);
    send_frame(8'h76, 1'b0, 1'b0);
    exp_q.push_back(8'h7A);
    send_frame(8'h1A, 1'b0, 1'b0);
    check_drained("back_to_back");
  endtask

  task automatic test_midframe_reset();
    logic [7:0] code;
    code = 8'h66;
    send_frame(8'h12, 1'b0, 1'b0);
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(code[i]);
    ps2_data = 1'b1;
    reset = 1'b1;
    wait_cycles(3);
    checks++;
    if (kbd.ascii !== 8'h00) begin failures++; $display("FAIL midreset_ascii got=%h required=00", kbd.ascii); end
    checks++;
    if (kbd.ld_ascii !== 1'b0 || kbd.frame_err !== 1'b0) begin
      failures++;
      $display("FAIL midreset_strobes got ld=%b err=%b required 0 0", kbd.ld_ascii, kbd.frame_err);
    end
    reset = 1'b0;
    wait_cycles(10);
    exp_q.push_back(8'h08);
    send_frame(8'h66, 1'b0, 1'b0);
    exp_q.push_back(8'h61);
    send_frame(8'h1C, 1'b0, 1'b0);
    check_drained("midreset");
  endtask

  task automatic test_glitch();
    ps2_data = 1'b0;
    wait_cycles(2);
    ps2_clk = 1'b0;
    wait_cycles(3);
    ps2_clk = 1'b1;
    wait_cycles(4);
    ps2_data = 1'b1;
    wait_cycles(2 * H);
    exp_q.push_back(8'h61);
    send_frame(8'h1C, 1'b0, 1'b0);
    wait_cycles(TMO + 20);
    check_drained("glitch");
  endtask

  initial begin
    test_reset();
    test_single();
    test_shift();
    test_parity_error();
    test_timeout();
    test_extended();
    test_back_to_back();
    test_midframe_reset();
    test_glitch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1);
  end

endmodule
